// File: rtl/truth_table_lut_pkg.sv
// truth_table_pkg: shared types, Cello-order lookup and parameter legality check
package truth_table_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_t;

    // Cello ordering: row 0 sits in the table MSB
    function automatic logic tt_bit(input logic [63:0] tbl, input int tt_w, input int row);
        return tbl[6'(tt_w - 1 - row)];
    endfunction

    function automatic bit params_ok(input int n_in, input int cfg_w);
        return n_in >= 1 && n_in <= 6 && cfg_w >= 1 && (cfg_w & (cfg_w - 1)) == 0 && cfg_w <= (1 << n_in);
    endfunction
endpackage

// File: rtl/truth_table_lut_if.sv
// truth_table_lut_if: configuration, evaluation and result signals of the truth-table gate
interface truth_table_lut_if #(parameter int N_IN = 3, parameter int CFG_W = 8);
    localparam int TT_W = 1 << N_IN;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_abort;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             sweep_start;
    logic             sweep_busy;
    logic             out_valid;
    logic             out_bit;
    logic [N_IN-1:0]  out_row;
    logic             out_sweep;
    logic [TT_W-1:0]  tt_active;

    modport slave (
        input  cfg_valid, cfg_data, cfg_abort, in_valid, in_data, sweep_start,
        output cfg_ready, in_ready, sweep_busy, out_valid, out_bit, out_row, out_sweep, tt_active
    );
    modport master (
        output cfg_valid, cfg_data, cfg_abort, in_valid, in_data, sweep_start,
        input  cfg_ready, in_ready, sweep_busy, out_valid, out_bit, out_row, out_sweep, tt_active
    );
endinterface

// File: rtl/truth_table_lut_cfg_loader.sv
// tt_cfg_loader: word-by-word table loader with abort and a one-cycle commit state
module tt_cfg_loader
    import truth_table_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid_i,
    input  logic [CFG_W-1:0]       cfg_data_i,
    input  logic                   cfg_abort_i,
    input  logic                   sweep_busy_i,
    output logic                   cfg_ready_o,
    output logic                   cfg_idle_o,
    output logic                   commit_pulse_o,
    output logic [(1<<N_IN)-1:0]   shadow_o
);
    localparam int TT_W = 1 << N_IN;
    localparam int NW   = TT_W / CFG_W;
    localparam int CW   = $clog2(NW + 1);

    cfg_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TT_W-1:0] shadow_q, shadow_d;
    logic [N_IN-1:0] base;
    logic            accept;

    assign cfg_ready_o    = (state_q == IDLE) ? !sweep_busy_i : (state_q == LOAD);
    assign accept         = cfg_valid_i & cfg_ready_o;
    // a word accepted this cycle starts a load, so a sweep must not start alongside it
    assign cfg_idle_o     = (state_q == IDLE) & ~accept;
    assign commit_pulse_o = state_q == COMMIT;
    assign shadow_o       = shadow_q;
    assign base           = N_IN'((NW - 1 - int'(cnt_q)) * CFG_W);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (state_q == COMMIT) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == LOAD && cfg_abort_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            shadow_d = '0;
        end else if (accept) begin
            shadow_d[base +: CFG_W] = cfg_data_i;
            cnt_d   = cnt_q + 1'b1;
            state_d = (int'(cnt_q) == NW - 1) ? COMMIT : LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end
endmodule

// File: rtl/truth_table_lut.sv
// truth_table_lut: runtime-programmable N-input truth-table gate with atomic reload and table sweep
module truth_table_lut
    import truth_table_pkg::*;
#(
    parameter int          N_IN     = 3,
    parameter int          CFG_W    = 8,
    parameter logic [63:0] RESET_TT = 64'h03
) (
    input logic              clk,
    input logic              rst_n,
    truth_table_lut_if.slave bus
);
    localparam int TT_W = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(TT_W - 1);

    if (!params_ok(N_IN, CFG_W)) begin : g_bad_params
        $error("truth_table_lut: illegal N_IN/CFG_W combination");
    end

    logic            commit_pulse, cfg_idle, in_acc, sweep_go, issue;
    logic [TT_W-1:0] shadow, tt_active_q;
    logic            sweep_busy_q, sweep_done_q;
    logic [N_IN-1:0] row_q, row_sel;
    logic            s1_valid_q, s1_bit_q, s1_sweep_q;
    logic [N_IN-1:0] s1_row_q;
    logic            out_valid_q, out_bit_q, out_sweep_q;
    logic [N_IN-1:0] out_row_q;

    tt_cfg_loader #(.N_IN(N_IN), .CFG_W(CFG_W)) u_loader (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (bus.cfg_valid),
        .cfg_data_i     (bus.cfg_data),
        .cfg_abort_i    (bus.cfg_abort),
        .sweep_busy_i   (sweep_busy_q),
        .cfg_ready_o    (bus.cfg_ready),
        .cfg_idle_o     (cfg_idle),
        .commit_pulse_o (commit_pulse),
        .shadow_o       (shadow)
    );

    assign in_acc   = bus.in_valid & ~sweep_busy_q;
    assign sweep_go = bus.sweep_start & cfg_idle & ~sweep_busy_q;
    // busy holds one drain cycle after the last row is issued
    assign issue    = sweep_busy_q & ~sweep_done_q;
    assign row_sel  = issue ? row_q : bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_active_q  <= TT_W'(RESET_TT);
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_bit_q     <= 1'b0;
            s1_sweep_q   <= 1'b0;
            s1_row_q     <= '0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_sweep_q  <= 1'b0;
            out_row_q    <= '0;
        end else begin
            if (commit_pulse) tt_active_q <= shadow;
            sweep_busy_q <= sweep_go | issue;
            sweep_done_q <= issue & (row_q == LAST_ROW);
            row_q        <= sweep_go ? '0 : (issue && row_q != LAST_ROW) ? row_q + 1'b1 : row_q;
            s1_valid_q   <= in_acc | issue;
            s1_row_q     <= row_sel;
            s1_bit_q     <= tt_bit(64'(tt_active_q), TT_W, 32'(row_sel));
            s1_sweep_q   <= issue;
            out_valid_q  <= s1_valid_q;
            out_bit_q    <= s1_bit_q;
            out_row_q    <= s1_row_q;
            out_sweep_q  <= s1_sweep_q;
        end
    end

    assign bus.in_ready   = ~sweep_busy_q;
    assign bus.sweep_busy = sweep_busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bit    = out_bit_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_sweep  = out_sweep_q;
    assign bus.tt_active  = tt_active_q;
endmodule

// File: tb/tb_truth_table_lut.sv
// tb_truth_table_lut: directed and random stimulus against a timeline-based reference model
module tb_truth_table_lut;
    localparam int N_IN  = 3;
    localparam int CFG_W = 4;
    localparam int TT_W  = 8;
    localparam int NW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    truth_table_lut_if #(.N_IN(N_IN), .CFG_W(CFG_W)) bus ();
    truth_table_lut #(.N_IN(N_IN), .CFG_W(CFG_W), .RESET_TT(64'h03)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {int due; int row; logic bv; logic sw;} exp_t;
    exp_t       exp_q[$];
    logic [7:0] m_tt, m_shadow;
    logic [3:0] m_words[$];
    logic       m_commit;
    bit         sw_on;
    int         sw_k, cyc;
    int         vectors = 0, miscompares = 0;

    function automatic logic ref_bit(input logic [7:0] t, input int r);
        return t[3'(TT_W - 1 - r)];
    endfunction

    function automatic bit m_busy(input int e);
        return sw_on && e >= sw_k + 1 && e <= sw_k + 1 + TT_W;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic idle();
        bus.cfg_valid = 0; bus.cfg_data = '0; bus.cfg_abort = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.sweep_start = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_tt_active", bus.tt_active, 8'h03);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sweep_busy", bus.sweep_busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bit", bus.out_bit, 0);
        chk("rst_out_sweep", bus.out_sweep, 0);
        chk("rst_out_row", bus.out_row, 0);
        m_tt = 8'h03; m_shadow = '0; m_words.delete(); m_commit = 0; sw_on = 0; exp_q.delete();
        @(negedge clk);
        rst_n = 1;
    endtask

    // one clock: predict handshakes, advance the model, then check results after the edge
    task automatic tick();
        bit busy, loading, cfg_rdy, cfg_acc, in_acc, sw_go;
        busy    = m_busy(cyc);
        loading = m_words.size() > 0;
        cfg_rdy = m_commit ? 0 : loading ? 1 : !busy;
        chk("in_ready", bus.in_ready, !busy);
        chk("cfg_ready", bus.cfg_ready, cfg_rdy);
        chk("sweep_busy", bus.sweep_busy, busy);
        cfg_acc = bus.cfg_valid && cfg_rdy;
        in_acc  = bus.in_valid && !busy;
        sw_go   = bus.sweep_start && !busy && !m_commit && !loading && !cfg_acc;
        if (in_acc) exp_q.push_back('{due: cyc + 1, row: int'(bus.in_data), bv: ref_bit(m_tt, int'(bus.in_data)), sw: 1'b0});
        if (sw_go) begin
            sw_on = 1; sw_k = cyc;
            for (int r = 0; r < TT_W; r++) exp_q.push_back('{due: cyc + 2 + r, row: r, bv: ref_bit(m_tt, r), sw: 1'b1});
        end
        if (m_commit) begin
            m_tt = m_shadow; m_commit = 0;
        end else if (loading && bus.cfg_abort) begin
            m_words.delete();
        end else if (cfg_acc) begin
            m_words.push_back(bus.cfg_data);
            if (m_words.size() == NW) begin
                m_shadow = {m_words[0], m_words[1]}; m_words.delete(); m_commit = 1;
            end
        end
        if (sw_on && cyc >= sw_k + 1 + TT_W) sw_on = 0;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_row", bus.out_row, exp_q[0].row);
            chk("out_bit", bus.out_bit, exp_q[0].bv);
            chk("out_sweep", bus.out_sweep, exp_q[0].sw);
            void'(exp_q.pop_front());
        end else chk("out_valid_idle", bus.out_valid, 0);
        chk("tt_active", bus.tt_active, m_tt);
        cyc++;
    endtask

    task automatic load2(input logic [3:0] hi, input logic [3:0] lo);
        idle(); bus.cfg_valid = 1; bus.cfg_data = hi; tick();
        bus.cfg_data = lo; tick();
        idle(); tick();
    endtask

    initial begin
        cyc = 0;
        idle();
        #2;
        do_reset();
        for (int r = 0; r < TT_W; r++) begin
            idle(); bus.in_valid = 1; bus.in_data = 3'(r); tick();
        end
        idle(); tick(); tick();
        bus.cfg_valid = 1; bus.cfg_data = 4'hE; tick();
        bus.cfg_data = 4'h8; tick();
        idle(); bus.in_valid = 1; bus.in_data = 3'd0; tick();
        tick();
        idle(); tick(); tick();
        chk("tt_after_e8", bus.tt_active, 8'hE8);
        bus.cfg_valid = 1; bus.cfg_data = 4'hA; tick();
        bus.cfg_abort = 1; bus.cfg_data = 4'hF; tick();
        bus.cfg_abort = 0;
        load2(4'h9, 4'h6);
        chk("tt_after_abort", bus.tt_active, 8'h96);
        bus.in_valid = 1; bus.in_data = 3'd7; tick();
        idle(); tick(); tick();
        bus.sweep_start = 1; bus.in_valid = 1; bus.in_data = 3'd5; tick();
        bus.sweep_start = 0;
        for (int i = 0; i < TT_W + 2; i++) tick();
        idle(); tick(); tick();
        bus.in_valid = 1; bus.cfg_valid = 1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 3'($urandom); bus.cfg_data = 4'($urandom); tick();
        end
        idle(); tick(); tick(); tick();
        bus.cfg_valid = 1; bus.cfg_data = 4'h5; tick();
        idle();
        do_reset();
        load2(4'hC, 4'h3);
        chk("tt_after_reload", bus.tt_active, 8'hC3);
        for (int i = 0; i < 400; i++) begin
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.in_data     = 3'($urandom);
            bus.cfg_valid   = ($urandom_range(0, 3) == 0);
            bus.cfg_data    = 4'($urandom);
            bus.cfg_abort   = ($urandom_range(0, 7) == 0);
            bus.sweep_start = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle();
        for (int i = 0; i < 14; i++) tick();
        chk("drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
